// File: rtl/axi_slave_pkg.sv
// axi_slave shared types and address map.
// Handshake FSM states and word addresses.
package axi_slave_pkg;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  localparam int ADDR_ID   = 0;
  localparam int ADDR_REG1 = 1;
  localparam int ADDR_REG2 = 2;
  localparam int ADDR_REG3 = 3;

endpackage

// File: rtl/axi_slave_if.sv
// axi_slave bus bundle.
// Write/read valid-ready channels with master/slave views.
interface axi_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rData;

  modport master (
    output awvalid,
    output awaddr,
    output wdata,
    output wvalid,
    output arvalid,
    output araddr,
    input  awready,
    input  wready,
    input  wresp,
    input  arready,
    input  rvalid,
    input  rData
  );

  modport slave (
    input  awvalid,
    input  awaddr,
    input  wdata,
    input  wvalid,
    input  arvalid,
    input  araddr,
    output awready,
    output wready,
    output wresp,
    output arready,
    output rvalid,
    output rData
  );

endinterface

// File: rtl/axi_slave_regfile.sv
// axi_slave register file: reg1..reg3 plus the ID word.
// Macro AXI_SLAVE_ID_REG_EN makes address 0 read ID_VALUE.
module axi_slave_regfile
  import axi_slave_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 2,
  parameter logic [31:0]     ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2,
  output logic [DATA_WIDTH-1:0] reg3
);

`ifdef AXI_SLAVE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] ID_WORD =
    ID_EN ? DATA_WIDTH'(ID_VALUE) : '0;

  localparam logic [ADDR_WIDTH-1:0] A_ID =
    ADDR_WIDTH'(ADDR_ID);
  localparam logic [ADDR_WIDTH-1:0] A_R1 =
    ADDR_WIDTH'(ADDR_REG1);
  localparam logic [ADDR_WIDTH-1:0] A_R2 =
    ADDR_WIDTH'(ADDR_REG2);
  localparam logic [ADDR_WIDTH-1:0] A_R3 =
    ADDR_WIDTH'(ADDR_REG3);

  // Load the addressed register; the ID slot ignores writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg1 <= '0;
      reg2 <= '0;
      reg3 <= '0;
    end else if (we) begin
      unique case (1'b1)
        (waddr == A_R1): reg1 <= wdata;
        (waddr == A_R2): reg2 <= wdata;
        (waddr == A_R3): reg3 <= wdata;
        default: ;
      endcase
    end
  end

  // Combinational read mux over the current contents.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (raddr == A_ID): rdata = ID_WORD;
      (raddr == A_R1): rdata = reg1;
      (raddr == A_R2): rdata = reg2;
      (raddr == A_R3): rdata = reg3;
      default:         rdata = '0;
    endcase
  end

endmodule

// File: rtl/axi_slave.sv
// axi_slave top: write and read handshake FSMs over the regfile.
// Optional ID readback at address 0 via AXI_SLAVE_ID_REG_EN.
module axi_slave
  import axi_slave_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 2,
  parameter logic [31:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_slave_if.slave            bus,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2,
  output logic [DATA_WIDTH-1:0] reg3
);

  wstate_e               wstate;
  rstate_e               rstate;
  logic                  whs;
  logic                  rhs;
  logic                  wresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_data;

  assign whs = bus.awvalid && bus.wvalid &&
               (wstate == W_IDLE) && !rst;
  assign rhs = bus.arvalid &&
               (rstate == R_IDLE) && !rst;

  assign bus.awready = whs;
  assign bus.wready  = whs;
  assign bus.arready = rhs;

  // A reset landing on the response cycle swallows the pulse.
  assign bus.wresp  = wresp_q && !rst;
  assign bus.rvalid = rvalid_q && !rst;
  assign bus.rData  = rdata_q;

  axi_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (whs),
    .waddr (bus.awaddr),
    .wdata (bus.wdata),
    .raddr (bus.araddr),
    .rdata (rd_data),
    .reg1  (reg1),
    .reg2  (reg2),
    .reg3  (reg3)
  );

  // Write channel: accept addr+data together, then one resp cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_IDLE;
      wresp_q <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (whs) begin
            wstate  <= W_RESP;
            wresp_q <= 1'b1;
          end
        end
        W_RESP: begin
          wstate  <= W_IDLE;
          wresp_q <= 1'b0;
        end
        default: begin
          wstate  <= W_IDLE;
          wresp_q <= 1'b0;
        end
      endcase
    end
  end

  // Read channel: capture data at accept, present it one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate   <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (rhs) begin
            rstate   <= R_DATA;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
          end
        end
        R_DATA: begin
          rstate   <= R_IDLE;
          rvalid_q <= 1'b0;
        end
        default: begin
          rstate   <= R_IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave.sv
// Scoreboard bench for axi_slave: directed phases then random traffic.
// Reference model tracks register contents and channel occupancy.
module tb_axi_slave;

  localparam int DW = 32;
  localparam int AW = 2;

`ifdef AXI_SLAVE_ID_REG_EN
  localparam logic [31:0] ID_EXP = 32'hA5A5_0001;
`else
  localparam logic [31:0] ID_EXP = 32'h0;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] reg1;
  logic [DW-1:0] reg2;
  logic [DW-1:0] reg3;

  axi_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_slave dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .reg1 (reg1),
    .reg2 (reg2),
    .reg3 (reg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wresp_cnt = 0;

  logic [31:0] mem [4];
  logic [31:0] last_rd;
  bit          wbusy;
  bit          rbusy;

  int          wq[$];
  int          rq_cyc[$];
  logic [31:0] rq_dat[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input int a);
    return (a == 0) ? ID_EXP : mem[a];
  endfunction

  // Reference model: evaluates acceptance at each edge.
  always @(posedge clk) begin
    bit whs, rhs;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      last_rd = '0;
      wbusy = 0;
      rbusy = 0;
    end else begin
      whs = bus.awvalid && bus.wvalid && !wbusy;
      rhs = bus.arvalid && !rbusy;
      if (rhs) begin
        last_rd = model_rd(int'(bus.araddr));
        rq_cyc.push_back(cyc);
        rq_dat.push_back(last_rd);
      end
      if (whs) begin
        if (bus.awaddr != 0) mem[bus.awaddr] = bus.wdata;
        wq.push_back(cyc);
      end
      wbusy = whs;
      rbusy = rhs;
    end
  end

  // Monitor: compares outputs mid-cycle, pops scoreboard entries.
  always @(negedge clk) begin
    bit ew, er;
    logic [31:0] ed;
    chk("awready", 32'(bus.awready),
        32'(!rst && bus.awvalid && bus.wvalid && !wbusy));
    chk("wready", 32'(bus.wready),
        32'(!rst && bus.awvalid && bus.wvalid && !wbusy));
    chk("arready", 32'(bus.arready),
        32'(!rst && bus.arvalid && !rbusy));
    ew = 0;
    if (wq.size() > 0 && wq[0] == cyc) begin
      void'(wq.pop_front());
      ew = !rst;
    end
    chk("wresp", 32'(bus.wresp), 32'(ew));
    if (bus.wresp) wresp_cnt++;
    er = 0;
    ed = '0;
    if (rq_cyc.size() > 0 && rq_cyc[0] == cyc) begin
      void'(rq_cyc.pop_front());
      ed = rq_dat.pop_front();
      er = !rst;
    end
    chk("rvalid", 32'(bus.rvalid), 32'(er));
    if (er && bus.rvalid) chk("rdata_pop", bus.rData, ed);
    chk("rdata_hold", bus.rData, last_rd);
    chk("reg1", reg1, mem[1]);
    chk("reg2", reg2, mem[2]);
    chk("reg3", reg3, mem[3]);
  end

  task automatic step(input bit aw, input bit w,
                      input bit ar, input int wa,
                      input logic [31:0] wd,
                      input int ra, input bit r);
    bus.awvalid = aw;
    bus.wvalid  = w;
    bus.arvalid = ar;
    bus.awaddr  = AW'(wa);
    bus.wdata   = wd;
    bus.araddr  = AW'(ra);
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    last_rd = '0;
    wbusy = 0;
    rbusy = 0;
    // reset with valids up: readies must stay low
    step(1, 1, 1, 3, 32'hDEAD_BEEF, 1, 1);
    step(1, 1, 1, 3, 32'hDEAD_BEEF, 1, 1);
    idle(2);
    // single write to reg3
    step(1, 1, 0, 3, 32'h1234_5678, 0, 0);
    idle(2);
    // write reg1 then read it back
    step(1, 1, 0, 1, 32'h8765_4321, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 1, 0);
    idle(2);
    // held valids for five cycles: three accepts
    c0 = wresp_cnt;
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 2, 32'hA000_0000 + i, 0, 0);
    idle(2);
    chk("held_wresp_count", wresp_cnt - c0, 3);
    // lone awvalid is never accepted; wvalid completes it
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 2, 32'h5555_AAAA, 0, 0);
    step(1, 1, 0, 2, 32'h5555_AAAA, 0, 0);
    idle(2);
    // address 0: ID read, write ignored but completes
    step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    c0 = wresp_cnt;
    step(1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    idle(2);
    chk("id_write_wresp", wresp_cnt - c0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    // same-edge read and write of reg3: old value read
    step(1, 1, 1, 3, 32'h0BAD_F00D, 3, 0);
    idle(2);
    // reset during response cycle swallows wresp
    c0 = wresp_cnt;
    step(1, 1, 1, 1, 32'hCAFE_0001, 2, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    chk("rst_abort_wresp", wresp_cnt - c0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0,
           int'($urandom_range(0, 3)),
           $urandom,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 49) == 0);
    end
    idle(4);
    chk("leftover_w", wq.size(), 0);
    chk("leftover_r", rq_cyc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
